// File: rtl/quad_encoder_emulator_pkg.sv
// Shared constants for the quadrature encoder emulator and its matching decoder.
// Phase encoding lists {A, B} in forward order, so A leads B when stepping up.
package quad_pkg;

   localparam logic [1:0] PH0 = 2'b00;
   localparam logic [1:0] PH1 = 2'b10;
   localparam logic [1:0] PH2 = 2'b11;
   localparam logic [1:0] PH3 = 2'b01;

   localparam logic DIR_FWD = 1'b0;
   localparam logic DIR_REV = 1'b1;

   // The decoder's input filter uses this same length.
   localparam int STEP_DIV_DEFAULT = 100;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_e;

   function automatic logic [1:0] phase_enc(input logic [1:0] idx);
      logic [1:0] ab;
      ab = PH0;
      case (idx)
         2'd0: ab = PH0;
         2'd1: ab = PH1;
         2'd2: ab = PH2;
         2'd3: ab = PH3;
         default: ab = PH0;
      endcase
      return ab;
   endfunction

endpackage

// File: rtl/quad_encoder_emulator_step_timer.sv
// Loadable 16-bit down-counter; ticks for one clock at zero and reloads the
// value captured at the last load, giving a jitter-free period of load+1.
module quad_step_timer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_load,
   input  logic [15:0] i_load_val,
   input  logic        i_en,
   output logic        o_tick
);

   logic [15:0] r_cnt;
   logic [15:0] r_reload;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_reload <= '0;
      end else if (i_load) begin
         r_cnt    <= i_load_val;
         r_reload <= i_load_val;
      end else if (i_en) begin
         if (r_cnt == 16'd0) r_cnt <= r_reload;
         else                r_cnt <= r_cnt - 16'd1;
      end
   end

   assign o_tick = i_en & (r_cnt == 16'd0);

endmodule

// File: rtl/quad_encoder_emulator.sv
// Quadrature encoder emulator: turns relative step commands into paced A/B
// edges and keeps a running count of the edges it has emitted.
module quad_encoder_emulator
   import quad_pkg::*;
#(
   parameter int STEP_DIV  = STEP_DIV_DEFAULT,
   parameter int POS_WIDTH = 24
) (
   input  logic                        CLK,
   input  logic                        reset_n,
   input  logic signed [15:0]          cmd_steps,
   input  logic        [15:0]          cmd_rate,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic                        abort,
   output logic                        quadA,
   output logic                        quadB,
   output logic signed [POS_WIDTH-1:0] position,
   output logic                        busy,
   output logic                        done
);

   localparam logic [15:0]                L_DIV = 16'(STEP_DIV);
   localparam logic signed [POS_WIDTH-1:0] L_ONE = POS_WIDTH'(1);

   state_e                       r_state, w_state_nxt;
   logic                         r_dir;
   logic [16:0]                  r_remaining;
   logic [1:0]                   r_phase;
   logic [1:0]                   r_ab;
   logic signed [POS_WIDTH-1:0]  r_pos;
   logic                         r_done;

   logic                         w_idle;
   logic                         w_accept;
   logic [16:0]                  w_steps_ext;
   logic [16:0]                  w_mag;
   logic [15:0]                  w_period;
   logic                         w_tick;
   logic                         w_step;
   logic                         w_last;
   logic [1:0]                   w_phase_nxt;

   assign w_idle      = (r_state == S_IDLE);
   // A zero-length command is consumed here but never leaves IDLE.
   assign w_accept    = w_idle & cmd_valid & (cmd_steps != 16'sd0);
   // 17 bits so that |-32768| is representable.
   assign w_steps_ext = {cmd_steps[15], cmd_steps};
   assign w_mag       = cmd_steps[15] ? (17'd0 - w_steps_ext) : w_steps_ext;
   assign w_period    = (cmd_rate < L_DIV) ? L_DIV : cmd_rate;

   quad_step_timer u_timer (
      .clk        (CLK),
      .rst_n      (reset_n),
      .i_load     (w_accept),
      .i_load_val (w_period - 16'd1),
      .i_en       (r_state == S_RUN),
      .o_tick     (w_tick)
   );

   // A due step always lands, even alongside abort, so completion beats abort.
   assign w_step      = (r_state == S_RUN) & w_tick;
   assign w_last      = w_step & (r_remaining == 17'd1);
   assign w_phase_nxt = (r_dir == DIR_REV) ? (r_phase - 2'd1) : (r_phase + 2'd1);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
         S_RUN:   if (w_last || abort) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         r_dir       <= DIR_FWD;
         r_remaining <= '0;
         r_phase     <= 2'd0;
         r_ab        <= PH0;
         r_pos       <= '0;
         r_done      <= 1'b0;
      end else begin
         r_done <= w_last;
         if (w_accept) begin
            r_dir       <= cmd_steps[15] ? DIR_REV : DIR_FWD;
            r_remaining <= w_mag;
         end else if (w_step) begin
            r_remaining <= r_remaining - 17'd1;
            r_phase     <= w_phase_nxt;
            r_ab        <= phase_enc(w_phase_nxt);
            r_pos       <= (r_dir == DIR_REV) ? (r_pos - L_ONE) : (r_pos + L_ONE);
         end
      end
   end

   assign quadA     = r_ab[1];
   assign quadB     = r_ab[0];
   assign position  = r_pos;
   assign busy      = (r_state == S_RUN);
   assign cmd_ready = w_idle;
   assign done      = r_done;

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Directed + randomized bench for quad_encoder_emulator against a net-edge model.
module tb_quad_encoder_emulator;

   localparam int SD = 2;
   localparam int PW = 16;

   logic                 CLK = 1'b0;
   logic                 reset_n = 1'b0;
   logic signed [15:0]   cmd_steps = '0;
   logic [15:0]          cmd_rate = '0;
   logic                 cmd_valid = 1'b0;
   logic                 abort = 1'b0;
   logic                 cmd_ready, quadA, quadB, busy, done;
   logic signed [PW-1:0] position;

   int total = 0;
   int bad = 0;
   logic signed [PW-1:0] pos_m;
   logic [1:0] gray [4];

   always #5 CLK = ~CLK;

   quad_encoder_emulator #(.STEP_DIV(SD), .POS_WIDTH(PW)) dut (
      .CLK(CLK), .reset_n(reset_n), .cmd_steps(cmd_steps), .cmd_rate(cmd_rate),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .abort(abort),
      .quadA(quadA), .quadB(quadB), .position(position), .busy(busy), .done(done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_ab"}, {30'd0, quadA, quadB}, {30'd0, gray[pos_m[1:0]]});
      chk({tag, "_pos"}, position, pos_m);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_ready"}, cmd_ready, 1);
      chk({tag, "_done"}, done, 0);
   endtask

   // Issue one command; abort_at >= 0 aborts one clock after that many edges.
   // hold_valid keeps cmd_valid high and scrambles the command inputs while running.
   task automatic run_cmd(input int steps, input int rate, input int abort_at, input bit hold_valid);
      int period, tgt, n, cyc, ndone, budget;
      logic [1:0] prev, ab;
      bit fin, aborted, edge_now;
      period = (rate > SD) ? rate : SD;
      tgt = (steps < 0) ? -steps : steps;
      n = 0; cyc = 0; ndone = 0; fin = 0; aborted = 0;
      budget = (tgt + 2) * period + 8;
      chk("ready_pre", cmd_ready, 1);
      prev = {quadA, quadB};
      cmd_steps = 16'(steps); cmd_rate = 16'(rate); cmd_valid = 1'b1;
      @(posedge CLK); #1;
      if (hold_valid && tgt != 0) begin
         cmd_steps = 16'sd7; cmd_rate = 16'd500;
      end else cmd_valid = 1'b0;
      chk("busy_acc", busy, tgt != 0);
      chk("ready_acc", cmd_ready, tgt == 0);
      if (tgt == 0) begin
         repeat (3 * period + 2) begin
            @(posedge CLK); #1;
            check_idle_outputs("zero");
         end
         cmd_valid = 1'b0;
         return;
      end
      while (!fin && cyc < budget) begin
         @(posedge CLK); #1; cyc++;
         ab = {quadA, quadB};
         edge_now = (ab != prev);
         if (edge_now) begin
            n++;
            pos_m = (steps < 0) ? pos_m - 16'sd1 : pos_m + 16'sd1;
            chk("edge_time", cyc, n * period);
            chk("phase", {30'd0, ab}, {30'd0, gray[pos_m[1:0]]});
            chk("one_bit", $countones(ab ^ prev), 1);
            chk("position", position, pos_m);
            prev = ab;
         end
         chk("done", done, edge_now && n == tgt);
         if (done) begin
            ndone++; fin = 1;
            chk("busy_end", busy, 0);
            chk("ready_end", cmd_ready, 1);
            cmd_valid = 1'b0;
         end else chk("busy_run", busy, 1);
         if (!fin && abort_at >= 0 && n == abort_at && cyc == n * period + 1) begin
            abort = 1'b1;
            @(posedge CLK); #1; cyc++;
            abort = 1'b0;
            check_idle_outputs("abort");
            fin = 1; aborted = 1;
         end
      end
      chk("finished", fin, 1);
      if (aborted) begin
         repeat (2 * period) begin
            @(posedge CLK); #1;
            check_idle_outputs("abort_quiet");
         end
         chk("abort_edges", n, abort_at);
      end else begin
         chk("edges", n, tgt);
         chk("done_cnt", ndone, 1);
         @(posedge CLK); #1;
         check_idle_outputs("post");
      end
   endtask

   task automatic do_reset();
      #3 reset_n = 1'b0;
      #1;
      pos_m = '0;
      chk("rst_ab", {30'd0, quadA, quadB}, 0);
      chk("rst_pos", position, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", cmd_ready, 1);
      @(posedge CLK); #1;
      reset_n = 1'b1;
   endtask

   initial begin
      int s, r;
      gray[0] = 2'b00; gray[1] = 2'b10; gray[2] = 2'b11; gray[3] = 2'b01;
      pos_m = '0;
      #1;
      @(posedge CLK); #1;
      do_reset();
      @(posedge CLK); #1;

      run_cmd(8, 200, -1, 0);
      chk("plan_fwd_ab", {30'd0, quadA, quadB}, 0);
      chk("plan_fwd_pos", position, 8);

      // Starts from phase 00: reverse walk 01,11,10,00,01, rate clamped to SD.
      run_cmd(-5, 1, -1, 1);
      chk("plan_rev_ab", {30'd0, quadA, quadB}, 32'b01);
      chk("plan_rev_pos", position, 3);

      run_cmd(0, 50, -1, 1);

      abort = 1'b1;
      @(posedge CLK); #1;
      abort = 1'b0;
      check_idle_outputs("abort_idle");

      run_cmd(10, 10, 3, 0);
      chk("plan_abort_pos", position, 6);
      run_cmd(1, 10, -1, 0);
      chk("plan_cont_pos", position, 7);

      repeat (12) begin
         s = int'($urandom_range(0, 24)) - 12;
         r = int'($urandom_range(0, 12));
         run_cmd(s, r, -1, 0);
      end

      // Asynchronous reset in the middle of a command.
      cmd_steps = 16'sd6; cmd_rate = 16'd4; cmd_valid = 1'b1;
      @(posedge CLK); #1;
      cmd_valid = 1'b0;
      repeat (13) @(posedge CLK);
      #1;
      chk("mid_busy", busy, 1);
      do_reset();
      @(posedge CLK); #1;
      check_idle_outputs("after_rst");

      run_cmd(-32768, 0, -1, 0);
      chk("plan_min_pos", position, -32768);
      run_cmd(-1, 3, -1, 0);
      chk("plan_wrap_neg", position, 32767);
      run_cmd(1, 3, -1, 0);
      chk("plan_wrap_pos", position, -32768);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
